pp_pipeline_accel_stream_rr_arb: RTL



---
 rtl/pp_pipeline_accel_stream_rr_arb.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pp_pipeline_accel_stream_rr_arb.sv
// rtl/pp_pipeline_accel_stream_rr_arb.sv - round-robin burst arbiter merging ap_fifo streams into one FIFO write port
module pp_pipeline_accel_stream_rr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_empty_n,
    output logic [NUM_REQ-1:0]            req_read,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dout,
    input  logic                          out_full_n,
    output logic                          out_write,
    output logic [DATA_WIDTH-1:0]         out_din,
    output logic                          grant_valid,
    output logic [ID_WIDTH-1:0]           grant_id
);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state, state_next;
    logic [ID_WIDTH-1:0] rr_ptr, rr_ptr_next;
    logic [ID_WIDTH-1:0] grant_id_next;
    logic                grant_valid_next;
    logic [CNT_W-1:0]    beat_cnt, beat_cnt_next;

    logic                win_found;
    logic [ID_WIDTH-1:0] win_id;
    logic [ID_WIDTH:0]   cand;
    logic [NUM_REQ-1:0]  owner_mask;
    logic                owner_ready;
    logic                last_beat;

    // Rotating priority search: offset k from rr_ptr, first non-empty stream wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_WIDTH+1)'(k);
            if (cand >= (ID_WIDTH+1)'(NUM_REQ))
                cand = cand - (ID_WIDTH+1)'(NUM_REQ);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!win_found && cand == (ID_WIDTH+1)'(i) && req_empty_n[i]) begin
                    win_found = 1'b1;
                    win_id    = ID_WIDTH'(i);
                end
            end
        end
    end

    always_comb begin
        owner_mask = '0;
        for (int i = 0; i < NUM_REQ; i++)
            owner_mask[i] = (grant_id == ID_WIDTH'(i));
    end

    assign owner_ready = |(req_empty_n & owner_mask);
    assign last_beat   = (beat_cnt == CNT_W'(BURST_LEN - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            beat_cnt    <= '0;
        end else begin
            state       <= state_next;
            rr_ptr      <= rr_ptr_next;
            grant_id    <= grant_id_next;
            grant_valid <= grant_valid_next;
            beat_cnt    <= beat_cnt_next;
        end
    end

    always_comb begin
        state_next       = state;
        rr_ptr_next      = rr_ptr;
        grant_id_next    = grant_id;
        grant_valid_next = grant_valid;
        beat_cnt_next    = beat_cnt;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_next       = GRANT;
                    grant_id_next    = win_id;
                    grant_valid_next = 1'b1;
                    beat_cnt_next    = '0;
                end
            end
            GRANT: begin
                // A bubble releases at once; backpressure alone holds the grant indefinitely.
                if (!owner_ready || (out_full_n && last_beat)) begin
                    state_next       = IDLE;
                    grant_valid_next = 1'b0;
                    rr_ptr_next      = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                            : grant_id + ID_WIDTH'(1);
                end
                if (owner_ready && out_full_n)
                    beat_cnt_next = beat_cnt + CNT_W'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_read  = '0;
        out_write = 1'b0;
        out_din   = '0;
        if (state == GRANT && owner_ready && out_full_n) begin
            req_read  = owner_mask;
            out_write = 1'b1;
        end
        if (grant_valid) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (owner_mask[i])
                    out_din = req_dout[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end
endmodule
